// File: rtl/pwm_capture.sv
// PWM capture: measures an incoming PWM waveform and recovers the generator's
// top (period - 1) and cmp (high time) settings, both in clock cycles.
module pwm_capture #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             pwm_in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] cmp,
  output logic             valid,
  output logic             locked,
  output logic             timeout,
  output logic             level,
  output logic [WIDTH-1:0] d_out
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC-1:0]  sync_q;
  logic             s_d_q;
  logic             s;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] cmp_q;
  logic             valid_q;
  logic             locked_q;
  logic             timeout_q;
  state_t           state_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pwm_in};
      s_d_q  <= sync_q[SYNC-1];
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Counter restarts on every rise, so at the next rise it holds period - 1.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A saturated counter means the waveform stalled; it overrides any edge in
  // the same cycle and discards the partial period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= WAIT_RISE;
      hi_q      <= '0;
      top_q     <= '0;
      cmp_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cnt_q == CNT_MAX) begin
        timeout_q <= 1'b1;
        locked_q  <= 1'b0;
        state_q   <= WAIT_RISE;
      end else begin
        case (state_q)
          WAIT_RISE: begin
            if (rise) state_q <= MEAS_HIGH;
          end
          MEAS_HIGH: begin
            if (fall) begin
              hi_q    <= cnt_q + 1'b1;
              state_q <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              top_q     <= cnt_q;
              cmp_q     <= hi_q;
              valid_q   <= 1'b1;
              locked_q  <= 1'b1;
              timeout_q <= 1'b0;
              state_q   <= MEAS_HIGH;
            end
          end
          default: state_q <= WAIT_RISE;
        endcase
      end
    end
  end

  always_comb begin
    d_out = '0;
    case (sel)
      2'b00:   d_out = top_q;
      2'b01:   d_out = cmp_q;
      2'b10:   d_out[2:0] = {timeout_q, locked_q, s};
      default: d_out = cnt_q;
    endcase
  end

  assign top     = top_q;
  assign cmp     = cmp_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign timeout = timeout_q;
  assign level   = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model compared every cycle,
// plus directed loopback, retune, timeout, minimum-waveform and reset scenarios.
module tb_pwm_capture;

  localparam int unsigned W  = 12;
  localparam int unsigned SY = 2;
  localparam int MAXC = (1 << W) - 1;

  logic         clk    = 1'b0;
  logic         nrst   = 1'b0;
  logic         pwm_in = 1'b0;
  logic [1:0]   sel    = 2'b00;
  logic [W-1:0] top;
  logic [W-1:0] cmp;
  logic [W-1:0] d_out;
  logic         valid;
  logic         locked;
  logic         timeout;
  logic         level;

  pwm_capture #(.WIDTH(W), .SYNC(SY)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .pwm_in (pwm_in),
    .sel    (sel),
    .top    (top),
    .cmp    (cmp),
    .valid  (valid),
    .locked (locked),
    .timeout(timeout),
    .level  (level),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pwm_in value seen at each clock edge, and edge timestamps.
  bit hist [int];
  int cyc       = 0;
  int last_rst  = 0;
  int anchor    = 0;
  int last_rise = 0;
  int last_fall = 0;
  int phase     = 0;   // 0 idle, 1 high seen after rise, 2 fall seen
  int e_top = 0, e_cmp = 0, e_valid = 0, e_locked = 0, e_timeout = 0;

  function automatic bit s_at(input int k);
    int idx;
    idx = k - int'(SY) + 1;
    if (idx <= last_rst || !hist.exists(idx)) return 1'b0;
    return hist[idx];
  endfunction

  always @(negedge clk) begin : model
    bit sk, sp;
    int c;
    int e_d;
    cyc++;
    hist[cyc+1] = pwm_in;
    if (!nrst) begin
      chk("rst_outs", {top, cmp, valid, locked, timeout, level}, '0);
      chk("rst_dout", d_out, 0);
      last_rst = cyc + 1;
      anchor   = cyc;
      phase    = 0;
      e_top = 0; e_cmp = 0; e_valid = 0; e_locked = 0; e_timeout = 0;
    end else begin
      sk = s_at(cyc);
      sp = s_at(cyc - 1);
      c = cyc - anchor - 1;
      if (c > MAXC) c = MAXC;
      case (sel)
        2'd0:    e_d = e_top;
        2'd1:    e_d = e_cmp;
        2'd2:    e_d = e_timeout * 4 + e_locked * 2 + int'(sk);
        default: e_d = c;
      endcase
      chk("m_top", top, e_top);
      chk("m_cmp", cmp, e_cmp);
      chk("m_valid", valid, e_valid);
      chk("m_locked", locked, e_locked);
      chk("m_timeout", timeout, e_timeout);
      chk("m_level", level, sk);
      chk("m_dout", d_out, e_d);
      if (valid === 1'b1) vcount++;
      e_valid = 0;
      if (c == MAXC) begin
        e_timeout = 1;
        e_locked  = 0;
        phase     = 0;
      end else if (sk && !sp) begin
        if (phase == 2) begin
          e_top     = cyc - last_rise - 1;
          e_cmp     = last_fall - last_rise;
          e_valid   = 1;
          e_locked  = 1;
          e_timeout = 0;
        end
        phase     = 1;
        last_rise = cyc;
      end else if (!sk && sp && phase == 1) begin
        last_fall = cyc;
        phase     = 2;
      end
      if (sk && !sp) anchor = cyc;
    end
  end

  task automatic gen(input int t, input int c, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i <= t; i++) begin
        @(posedge clk); #2 pwm_in = (i < c);
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #2 pwm_in = v;
    end
  endtask

  task automatic set_sel(input logic [1:0] s);
    @(posedge clk); #2 sel = s; #1;
  endtask

  initial begin : stim
    int v0;
    repeat (4) @(posedge clk);
    #2 nrst = 1'b1;
    #1;
    chk("reset_top", top, 0);
    chk("reset_cmp", cmp, 0);
    chk("reset_flags", {valid, locked, timeout, level}, 0);

    // Loopback at top=9, cmp=3
    gen(9, 3, 3);
    v0 = vcount;
    gen(9, 3, 5);
    #1;
    chk("loop_valid_count", vcount - v0, 5);
    chk("loop_top", top, 9);
    chk("loop_cmp", cmp, 3);
    chk("loop_locked", locked, 1);

    // Readback while in the low part of a period
    set_sel(2'b00); chk("rb_top", d_out, 9);
    set_sel(2'b01); chk("rb_cmp", d_out, 3);
    set_sel(2'b10); chk("rb_status", d_out, 16'h0002);
    set_sel(2'b11);

    // Retune to top=4, cmp=2 (counter readback stays selected)
    gen(4, 2, 6);
    #1;
    chk("retune_top", top, 4);
    chk("retune_cmp", cmp, 2);
    v0 = vcount;
    gen(4, 2, 4);
    #1;
    chk("retune_valid_count", vcount - v0, 4);

    // 0% duty timeout after lock at 9/3
    sel = 2'b00;
    gen(9, 3, 4);
    hold(1'b0, MAXC + 40);
    #1;
    chk("to0_timeout", timeout, 1);
    chk("to0_locked", locked, 0);
    chk("to0_level", level, 0);
    chk("to0_top", top, 9);
    chk("to0_cmp", cmp, 3);

    // 100% duty timeout after relock
    gen(9, 3, 4);
    #1;
    chk("relock_timeout", timeout, 0);
    hold(1'b1, MAXC + 40);
    #1;
    chk("to1_timeout", timeout, 1);
    chk("to1_locked", locked, 0);
    chk("to1_level", level, 1);
    chk("to1_top", top, 9);
    set_sel(2'b10); chk("to1_status", d_out, 16'h0005);
    sel = 2'b01;

    // Minimum waveform: 1 high, 1 low
    gen(1, 1, 6);
    v0 = vcount;
    gen(1, 1, 10);
    #1;
    chk("min_valid_count", vcount - v0, 10);
    chk("min_top", top, 1);
    chk("min_cmp", cmp, 1);
    chk("min_locked", locked, 1);

    // Reset pulse in the middle of the low phase
    gen(9, 3, 3);
    hold(1'b1, 3);
    hold(1'b0, 3);
    @(posedge clk); #2 nrst = 1'b0; pwm_in = 1'b0;
    #1;
    chk("mid_rst_top", top, 0);
    chk("mid_rst_cmp", cmp, 0);
    chk("mid_rst_flags", {valid, locked, timeout, level}, 0);
    chk("mid_rst_dout", d_out, 0);
    @(posedge clk); #2 nrst = 1'b1;
    v0 = vcount;
    gen(9, 3, 1);
    #1;
    chk("arm_only_valid", vcount - v0, 0);
    chk("arm_only_locked", locked, 0);
    gen(9, 3, 2);
    #1;
    chk("rearm_valid_count", vcount - v0, 2);
    chk("rearm_top", top, 9);
    chk("rearm_cmp", cmp, 3);
    chk("rearm_locked", locked, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
